// File: rtl/hfrv_trace_pkg.sv
// hfrv_trace_pkg: shared types and helpers for the retired-instruction trace buffer.
//
// Contents:
//   SEQ_MAX_W     widest sequence number an entry can hold; the top stores SEQ_W bits
//                 zero-extended into this field, so SEQ_W must not exceed it.
//   trace_entry_t one buffered retire record {pc, instr, seq, ts}; the ts field only
//                 exists when HFRV_TRACE_TIMESTAMP_EN is defined.
//   ptr_w()       pointer width for a given power-of-two depth.
//
// Configuration macro: HFRV_TRACE_TIMESTAMP_EN (adds the per-entry 32-bit timestamp).

package hfrv_trace_pkg;

    localparam int unsigned SEQ_MAX_W = 32;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic [SEQ_MAX_W-1:0] seq;
`ifdef HFRV_TRACE_TIMESTAMP_EN
        logic [31:0]          ts;
`endif
    } trace_entry_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/hfrv_trace_ram.sv
// hfrv_trace_ram: DEPTH x trace_entry_t register array for the trace FIFO.
//
// One synchronous write port, one asynchronous (combinational) read port so the
// FIFO head can be presented first-word-fall-through. Reset clears every slot,
// which keeps the stale head at zero after reset.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, clears storage
//   we     in   write enable
//   waddr  in   write slot
//   wdata  in   entry to write
//   raddr  in   read slot
//   rdata  out  entry at raddr (combinational)
//
// Configuration macro: HFRV_TRACE_TIMESTAMP_EN (changes trace_entry_t width only).

module hfrv_trace_ram
    import hfrv_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  trace_entry_t     wdata,
    input  logic [PTR_W-1:0] raddr,
    output trace_entry_t     rdata
);

    trace_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hfrv_trace_fifo.sv
// hfrv_trace_fifo: retired-instruction trace buffer between the core and the monitor.
//
// Every capture (enable && in_valid) consumes a sequence number. The entry is stored
// unless the FIFO is full with no pop in the same cycle, in which case it is dropped,
// overflow sticks high and drop_cnt counts up (saturating). The core is never stalled.
// The head is presented first-word-fall-through on a valid/ready stream.
//
// Parameters:
//   DEPTH  FIFO entries, power of two, >= 2
//   SEQ_W  sequence-number and drop-counter width, <= 32
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   enable                  capture enable; in_valid ignored while low
//   in_valid/in_pc/in_instr retire strobe and payload from the core
//   out_valid/out_ready     head handshake to the monitor
//   out_pc/out_instr/out_seq head entry fields
//   out_ts                  head timestamp (only with HFRV_TRACE_TIMESTAMP_EN)
//   count                   occupancy
//   overflow                sticky: an entry was dropped since reset
//   drop_cnt                dropped entries, saturating
//
// Configuration macro: HFRV_TRACE_TIMESTAMP_EN adds a free-running 32-bit cycle
// counter, per-entry ts storage and the out_ts port.

module hfrv_trace_fifo
    import hfrv_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SEQ_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_valid,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
    output logic [SEQ_W-1:0]       out_seq,
`ifdef HFRV_TRACE_TIMESTAMP_EN
    output logic [31:0]            out_ts,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [SEQ_W-1:0]       drop_cnt
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    logic capture, full, push, pop, drop;

    trace_entry_t wr_entry;
    trace_entry_t rd_entry;

`ifdef HFRV_TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;

    // Free-running; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end
`endif

    assign capture = enable && in_valid;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop     = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = in_pc;
        wr_entry.instr = in_instr;
        wr_entry.seq   = SEQ_MAX_W'(seq_q);
`ifdef HFRV_TRACE_TIMESTAMP_EN
        wr_entry.ts    = ts_q;
`endif
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Dropped captures still burn a sequence number so the loss shows as a gap.
        if (capture) begin
            seq_d = seq_q + SEQ_W'(1);
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + SEQ_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    hfrv_trace_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign out_valid = (count_q != '0);
    assign out_pc    = rd_entry.pc;
    assign out_instr = rd_entry.instr;
    assign out_seq   = rd_entry.seq[SEQ_W-1:0];
`ifdef HFRV_TRACE_TIMESTAMP_EN
    assign out_ts    = rd_entry.ts;
`endif
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    // Seq bits above SEQ_W are always written as zero and never read.
    if (SEQ_W < SEQ_MAX_W) begin : g_seq_hi
        logic seq_hi_unused;
        assign seq_hi_unused = ^rd_entry.seq[SEQ_MAX_W-1:SEQ_W];
    end

endmodule

// File: doc/hfrv_trace_fifo.md
# hfrv_trace_fifo

Retired-instruction trace buffer between the HF-RISC core and the verification monitor. Each cycle the core retires an instruction, it presents PC and instruction word; this block timestamps, sequence-numbers and buffers them. It exposes them on a valid/ready stream that the monitor drains at its own pace. The core is never back-pressured: overflow drops entries and records the loss.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- SEQ_W, 16: sequence-number and drop-counter width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  capture enable; when low, in_valid is ignored entirely.
- in_valid  in  1  retire strobe from core; one instruction per asserted cycle.
- in_pc  in  32  retired PC.
- in_instr  in  32  retired instruction word.
- out_valid  out  1  head entry available.
- out_ready  in  1  monitor accepts head entry.
- out_pc  out  32  head PC.
- out_instr  out  32  head instruction.
- out_seq  out  SEQ_W  head sequence number.
- out_ts  out  32  head timestamp (only with HFRV_TRACE_TIMESTAMP_EN).
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one entry dropped since reset.
- drop_cnt  out  SEQ_W  dropped entries, saturating.

## Operation
- Capture event: enable && in_valid in a cycle. Every capture event consumes one sequence number: seq increments by 1 mod 2^SEQ_W, whether the entry is stored or dropped. Drops therefore appear as gaps in out_seq.
- Push: on a capture event with the FIFO not full, or full with a simultaneous pop. Stores {pc, instr, seq, ts} at wr_ptr. wr_ptr advances mod DEPTH.
- Drop: on a capture event with the FIFO full and no pop. Nothing is stored. overflow is set to 1. drop_cnt increments, saturating at 2^SEQ_W−1.
- Pop: out_valid && out_ready. rd_ptr advances mod DEPTH.
- Occupancy:
  - push+pop in the same cycle: count unchanged. Valid at any occupancy, including full and the empty-with-push case; see below.
  - push only: count+1.
  - pop only: count−1.
- Empty with push and out_ready high: there is no pop, because out_valid is 0. The entry is stored normally.
- out_valid = (count != 0). The out_* fields are the head entry, first-word-fall-through. They are undefined-but-stable while out_valid is 0; the implementation drives the stale slot.
- Stream rule: while out_valid && !out_ready, the out_* fields hold.
- Reset values: out_valid 0, count 0, overflow 0, drop_cnt 0, seq 0, ts counter 0, pointers 0, out_pc/out_instr/out_seq/out_ts 0 (storage cleared). Reset mid-stream discards all contents. A capture event in the reset cycle is ignored.

## Timing
- Push-to-out_valid latency: 1 cycle. An entry captured at edge N is visible after edge N and poppable in cycle N+1.
- Pop takes effect at the clock edge. The next head is visible the following cycle; back-to-back pops sustain 1 entry/cycle.
- count, overflow and drop_cnt update at the same edge as the push, pop or drop that causes them.
- Timestamp counter: 32-bit, free-running from reset, +1 per cycle, wraps 0xFFFFFFFF→0. The stored ts is the counter value in the capture cycle; the first cycle after reset is ts 0.

## Configuration
- HFRV_TRACE_TIMESTAMP_EN defined:
  - 32-bit cycle counter present.
  - ts is stored per entry.
  - out_ts port exists.
- Undefined:
  - no counter, no ts storage, no out_ts port.
  - All other behaviour is identical.

## Structure
- Package hfrv_trace_pkg: typedef trace_entry_t, a packed struct {pc, instr, seq, ts[conditional]}; localparam PTR_W = $clog2(DEPTH) helper function.
- Sub-module hfrv_trace_ram: DEPTH×trace_entry_t register array with one write port and an asynchronous read port. The top holds pointers, counters and drop logic.

## Test plan
- Reset, then capture 3 retires (pc 0x100/0x104/0x108) with out_ready=0 → count=3, out_seq=0, out_pc=0x100. Then raise out_ready for 3 cycles → pops in order with seq 0,1,2, then out_valid=0.
- DEPTH=16, out_ready=0, 20 consecutive captures → count=16, overflow=1, drop_cnt=4. Drain → seq 0..15. The next capture gets seq 20.
- Full FIFO, capture and pop in the same cycle → count stays 16, drop_cnt unchanged, the new entry is at the tail.
- enable=0 with 5 in_valid pulses → count=0 and seq unchanged. Then one capture → out_seq=0.
- Macro defined: capture at the 10th cycle after reset release → out_ts=9. Force the counter near wrap, capture at 0xFFFFFFFF and the next cycle → ts 0xFFFFFFFF, then 0x0.
- Reset asserted with count=7 and overflow=1 → next cycle count=0, out_valid=0, overflow=0, drop_cnt=0. A capture during reset is not stored.
